// File: rtl/wrr_scheduler.sv
// wrr_scheduler: weighted round-robin pop scheduler for the four class FIFOs.
// Each queue receives up to W[i] consecutive pops per round; pause holds all pops.
// Build macro WRR_STRICT0_EN: queue 0 gets strict priority and leaves the rotation.
module wrr_scheduler #(
  parameter int WW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [3:0]    empty,
  input  logic          pause,
  input  logic          cfg_wr,
  input  logic [1:0]    cfg_sel,
  input  logic [WW-1:0] cfg_weight,
  output logic [3:0]    pop,
  output logic          valid,
  output logic [1:0]    grant_id,
  output logic          idle
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SERVE  = 2'd1,
    S_RELOAD = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [WW-1:0] weight [4];
  logic [WW-1:0] credit [4];
  logic [3:0]    elig;
  logic [3:0]    elig_cr;
  logic [3:0]    adv_mask;
  logic          any_elig;
  logic          strict_hit;
  logic [2:0]    idle_pick;
  logic [2:0]    adv_pick;
  logic [3:0]    pop_c;
  logic          cr_dec;
  logic          cr_clr;
  logic          cr_load;
  logic          vld_p1;

  // First set bit of mask scanning start, start+1, ... (mod 4); MSB of result is "found".
  function automatic logic [2:0] pick_from(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    pick_from = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) pick_from = {1'b1, idx};
    end
  endfunction

  // Credit decrement clamped at zero so the counter can never wrap.
  function automatic logic [WW-1:0] credit_dec_sat(input logic [WW-1:0] c);
    credit_dec_sat = (c == '0) ? '0 : c - WW'(1);
  endfunction

  // Eligibility masks for the rotation and the candidate picks for IDLE and advance.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig[i]    = !empty[i] && (weight[i] != '0);
      elig_cr[i] = elig[i] && (credit[i] != '0);
    end
`ifdef WRR_STRICT0_EN
    strict_hit = elig[0];
    elig[0]    = 1'b0;
    elig_cr[0] = 1'b0;
`else
    strict_hit = 1'b0;
`endif
    any_elig  = |elig;
    adv_mask  = elig_cr & ~(4'b0001 << ptr);
    idle_pick = pick_from(elig_cr, ptr);
    adv_pick  = pick_from(adv_mask, ptr + 2'd1);
  end

  // Next-state, pop selection and credit update requests.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    pop_c     = '0;
    cr_dec    = 1'b0;
    cr_clr    = 1'b0;
    cr_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (strict_hit && !pause) begin
          pop_c = 4'b0001;
        end else if (idle_pick[2]) begin
          state_nxt = S_SERVE;
          ptr_nxt   = idle_pick[1:0];
        end else if (any_elig) begin
          state_nxt = S_RELOAD;
        end
      end
      S_SERVE: begin
        if (!pause) begin
          if (strict_hit) begin
            pop_c = 4'b0001;
          end else begin
            if (elig_cr[ptr]) begin
              pop_c[ptr] = 1'b1;
              cr_dec     = 1'b1;
            end else begin
              // Queue ran dry or was disabled: forfeit what is left and move on.
              cr_clr = 1'b1;
            end
            if (!elig_cr[ptr] || credit[ptr] == WW'(1)) begin
              if (adv_pick[2]) begin
                ptr_nxt = adv_pick[1:0];
              end else if (any_elig) begin
                state_nxt = S_RELOAD;
              end else begin
                state_nxt = S_IDLE;
              end
            end
          end
        end
      end
      S_RELOAD: begin
        cr_load   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers: FSM state, service pointer and the read-data valid marker.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      ptr    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      vld_p1 <= |pop_c;
    end
  end

  // Weights and credits; a reload samples the weights as they were before this edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        weight[i] <= WW'(1);
        credit[i] <= WW'(1);
      end
    end else begin
      if (cfg_wr) weight[cfg_sel] <= cfg_weight;
      if (cr_load) begin
        for (int i = 0; i < 4; i++) credit[i] <= weight[i];
      end else if (cr_dec) begin
        credit[ptr] <= credit_dec_sat(credit[ptr]);
      end else if (cr_clr) begin
        credit[ptr] <= '0;
      end
    end
  end

  assign pop      = RESET ? 4'b0000 : pop_c;
  assign valid    = vld_p1;
  assign grant_id = ptr;
  assign idle     = (state == S_IDLE);

endmodule

// File: tb/tb_wrr_scheduler.sv
// tb_wrr_scheduler: randomized and directed bench for wrr_scheduler with a
// queue-level reference model of the weighted round-robin rules.
module tb_wrr_scheduler;

  localparam int WW = 4;

  logic          CLK;
  logic          RESET;
  logic [3:0]    empty;
  logic          pause;
  logic          cfg_wr;
  logic [1:0]    cfg_sel;
  logic [WW-1:0] cfg_weight;
  logic [3:0]    pop;
  logic          valid;
  logic [1:0]    grant_id;
  logic          idle;

  wrr_scheduler #(.WW(WW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .empty     (empty),
    .pause     (pause),
    .cfg_wr    (cfg_wr),
    .cfg_sel   (cfg_sel),
    .cfg_weight(cfg_weight),
    .pop       (pop),
    .valid     (valid),
    .grant_id  (grant_id),
    .idle      (idle)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO occupancy, refill policy and per-window pop counts.
  int cnt[4];
  bit keep_full[4];
  int win[4];

  // Reference model: 0 = idle, 1 = serve, 2 = reload.
  int m_mode;
  int m_p;
  int m_w[4];
  int m_c[4];
  bit m_valid;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_p     = 0;
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 1;
      m_c[i] = 1;
    end
  endtask

  function automatic int next_ready(input logic [3:0] ec, input int start, input int first_off);
    for (int k = first_off; k < 4; k++)
      if (ec[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  // One clock of the scheduling rules; returns this cycle's expected pop vector.
  task automatic model_step(output logic [3:0] ep);
    logic [3:0] el;
    logic [3:0] ec;
    bit strict;
    int nxt;
    int nmode;
    int np;
    int nc[4];
    ep = 4'b0000;
    for (int i = 0; i < 4; i++) el[i] = (cnt[i] > 0) && (m_w[i] != 0);
    strict = 1'b0;
`ifdef WRR_STRICT0_EN
    strict = el[0];
    el[0]  = 1'b0;
`endif
    for (int i = 0; i < 4; i++) ec[i] = el[i] && (m_c[i] > 0);
    nmode = m_mode;
    np    = m_p;
    nc    = m_c;
    if (m_mode == 0) begin
      if (!pause && strict) ep[0] = 1'b1;
      else begin
        nxt = next_ready(ec, m_p, 0);
        if (nxt >= 0) begin
          nmode = 1;
          np    = nxt;
        end else if (el != 0) nmode = 2;
      end
    end else if (m_mode == 1) begin
      if (!pause) begin
        if (strict) ep[0] = 1'b1;
        else begin
          if (ec[m_p]) begin
            ep[m_p]  = 1'b1;
            nc[m_p]  = m_c[m_p] - 1;
          end else nc[m_p] = 0;
          if (!(ec[m_p] && nc[m_p] > 0)) begin
            nxt = next_ready(ec, m_p, 1);
            if (nxt >= 0) np = nxt;
            else if (el != 0) nmode = 2;
            else nmode = 0;
          end
        end
      end
    end else begin
      nc    = m_w;
      nmode = 0;
    end
    if (cfg_wr) m_w[cfg_sel] = int'(cfg_weight);
    m_mode  = nmode;
    m_p     = np;
    m_c     = nc;
    m_valid = |ep;
  endtask

  // Drive one cycle of inputs, check all outputs mid-cycle, advance model and FIFOs.
  task automatic cycle(input bit p_in, input bit wr, input logic [1:0] sel, input logic [WW-1:0] wt);
    logic [3:0] ep;
    int ev;
    int eg;
    int ei;
    for (int i = 0; i < 4; i++) begin
      if (keep_full[i] && cnt[i] < 8) cnt[i] = 8;
      empty[i] = (cnt[i] == 0);
    end
    pause      = p_in;
    cfg_wr     = wr;
    cfg_sel    = sel;
    cfg_weight = wt;
    @(negedge CLK);
    ev = int'(m_valid);
    eg = m_p;
    ei = (m_mode == 0) ? 1 : 0;
    model_step(ep);
    chk_val("pop", 32'(pop), 32'(ep));
    chk_val("valid", 32'(valid), 32'(ev));
    chk_val("grant_id", 32'(grant_id), 32'(eg));
    chk_val("idle", 32'(idle), 32'(ei));
    chk_val("pop_when_empty", 32'(pop & empty), 32'd0);
    if (p_in) chk_val("pop_in_pause", 32'(pop), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) win[i]++;
      if (ep[i] && cnt[i] > 0) cnt[i]--;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 2'd0, '0);
  endtask

  task automatic set_w(input logic [1:0] sel, input logic [WW-1:0] wt);
    cycle(1'b0, 1'b1, sel, wt);
  endtask

  task automatic clr_win();
    for (int i = 0; i < 4; i++) win[i] = 0;
  endtask

  task automatic chk_window(input string tag, input int a, input int b, input int c, input int d);
    int e[4];
    e = '{a, b, c, d};
    for (int i = 0; i < 4; i++) chk_val($sformatf("%s_q%0d", tag, i), 32'(win[i]), 32'(e[i]));
  endtask

  // Asynchronous reset pulse between edges; outputs must drop at once.
  task automatic pulse_reset();
    cfg_wr = 1'b0;
    RESET  = 1'b1;
    #1;
    chk_val("rst_pop", 32'(pop), 32'd0);
    chk_val("rst_idle", 32'(idle), 32'd1);
    chk_val("rst_grant", 32'(grant_id), 32'd0);
    chk_val("rst_valid", 32'(valid), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    bit did_rst;
    bit found;
    int pause_left;
    bit pz;
    RESET      = 1'b1;
    pause      = 1'b0;
    cfg_wr     = 1'b0;
    cfg_sel    = '0;
    cfg_weight = '0;
    empty      = 4'hF;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cnt[i]       = 0;
      keep_full[i] = 1'b0;
      win[i]       = 0;
    end
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Reset state held with every FIFO empty.
    for (int n = 0; n < 10; n++) begin
      cycle(1'b0, 1'b0, 2'd0, '0);
      chk_val("init_idle", 32'(idle), 32'd1);
      chk_val("init_pop", 32'(pop), 32'd0);
      chk_val("init_valid", 32'(valid), 32'd0);
      chk_val("init_grant", 32'(grant_id), 32'd0);
    end

    // Weights 3,2,1,1 with full queues: 9-cycle rounds in steady state.
    set_w(2'd0, 4'd3);
    set_w(2'd1, 4'd2);
    set_w(2'd2, 4'd1);
    set_w(2'd3, 4'd1);
    for (int i = 0; i < 4; i++) keep_full[i] = 1'b1;
    run(20);
    clr_win();
    run(36);
`ifdef WRR_STRICT0_EN
    chk_window("wrr3211", 36, 0, 0, 0);
`else
    chk_window("wrr3211", 12, 8, 4, 4);
`endif

    // Disable queue 3, then re-enable it with weight 2.
    set_w(2'd3, 4'd0);
    run(20);
    clr_win();
    run(32);
`ifdef WRR_STRICT0_EN
    chk_window("w3_off", 32, 0, 0, 0);
`else
    chk_window("w3_off", 12, 8, 4, 0);
`endif
    set_w(2'd3, 4'd2);
    run(20);
    clr_win();
    run(40);
`ifdef WRR_STRICT0_EN
    chk_window("w3_two", 40, 0, 0, 0);
`else
    chk_window("w3_two", 12, 8, 4, 8);
`endif

    // All weights 4, queue 1 holding a single entry.
    for (int i = 0; i < 4; i++) set_w(2'(i), 4'd4);
    keep_full[1] = 1'b0;
    cnt[1]       = 1;
    clr_win();
    run(40);
`ifdef WRR_STRICT0_EN
    chk_val("single_q1", 32'(win[1]), 32'd0);
`else
    chk_val("single_q1", 32'(win[1]), 32'd1);
`endif
    keep_full[1] = 1'b1;

`ifndef WRR_STRICT0_EN
    // Pause in the middle of queue 2's credits; it resumes with 2 pops left.
    set_w(2'd0, 4'd1);
    set_w(2'd1, 4'd1);
    set_w(2'd2, 4'd4);
    set_w(2'd3, 4'd1);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (m_mode == 1 && m_p == 2 && m_c[2] == 2) found = 1'b1;
      else cycle(1'b0, 1'b0, 2'd0, '0);
    end
    chk_val("pause_setup", 32'(found), 32'd1);
    clr_win();
    for (int n = 0; n < 5; n++) cycle(1'b1, 1'b0, 2'd0, '0);
    chk_window("paused", 0, 0, 0, 0);
    clr_win();
    cycle(1'b0, 1'b0, 2'd0, '0);
    chk_val("resume1_q2", 32'(win[2]), 32'd1);
    clr_win();
    cycle(1'b0, 1'b0, 2'd0, '0);
    chk_val("resume2_q2", 32'(win[2]), 32'd1);
    clr_win();
    cycle(1'b0, 1'b0, 2'd0, '0);
    chk_val("resume3_q2", 32'(win[2]), 32'd0);
`endif

    // Random traffic, pauses, weight writes and one reset mid-service.
    for (int i = 0; i < 4; i++) keep_full[i] = 1'b0;
    did_rst    = 1'b0;
    pause_left = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!did_rst && n > 300 && m_mode == 1) begin
        pulse_reset();
        did_rst = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) cnt[i] += int'($urandom_range(1, 3));
        if (cnt[i] > 20) cnt[i] = 20;
      end
      if (pause_left > 0) begin
        pz = 1'b1;
        pause_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        pz = 1'b1;
        pause_left = int'($urandom_range(0, 5));
      end else pz = 1'b0;
      cycle(pz, ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), WW'($urandom_range(0, 15)));
    end
    chk_val("mid_serve_reset", 32'(did_rst), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
